// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master controller.
// Holds the transfer FSM encoding, the one-hot select width and the default parameter values.
package apb_master_pkg;

  localparam int PSEL_WIDTH          = 16;
  localparam int DEF_PADDR_WIDTH     = 32;
  localparam int DEF_PWDATA_WIDTH    = 32;
  localparam int DEF_PRDATA_WIDTH    = 32;
  localparam int DEF_PSEL_LSB        = 12;
  localparam int DEF_TIMEOUT_CYCLES  = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic logic [PSEL_WIDTH-1:0] decode_psel(input logic [3:0] idx);
    return PSEL_WIDTH'(1) << idx;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter: counts stalled cycles and flags when the configured limit is reached.
// A limit of zero never expires.
module apb_timeout_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             pclock,
  input  logic             preset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Saturating so a disabled timeout can stall indefinitely without wrapping.
  always_ff @(posedge pclock) begin
    if (preset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (limit != '0) && (count == limit);

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB master: turns a valid/ready command into a SETUP/ACCESS transfer
// and returns a one-cycle response, aborting stalled transfers after a configurable wait.
module apb_master_ctrl
  import apb_master_pkg::*;
#(
  parameter int PADDR_WIDTH    = DEF_PADDR_WIDTH,
  parameter int PWDATA_WIDTH   = DEF_PWDATA_WIDTH,
  parameter int PRDATA_WIDTH   = DEF_PRDATA_WIDTH,
  parameter int PSEL_LSB       = DEF_PSEL_LSB,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [PADDR_WIDTH-1:0]  cmd_addr,
  input  logic [PWDATA_WIDTH-1:0] cmd_wdata,
  output logic                    rsp_valid,
  output logic [PRDATA_WIDTH-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [PADDR_WIDTH-1:0]  paddr,
  output logic                    prwd,
  output logic [PWDATA_WIDTH-1:0] pwdata,
  output logic [PSEL_WIDTH-1:0]   psel,
  output logic                    penable,
  input  logic                    pready,
  input  logic [PRDATA_WIDTH-1:0] prdata,
  input  logic                    pslverr
);

  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  apb_state_e state, state_next;
  logic       accept;
  logic       complete;
  logic       timed_out;
  logic       expired;

  assign cmd_ready = (state == IDLE) && !preset;
  assign accept    = cmd_valid && cmd_ready;
  assign penable   = (state == ACCESS);
  // A ready slave on the limit cycle still counts as a normal completion.
  assign complete  = (state == ACCESS) && pready;
  assign timed_out = (state == ACCESS) && !pready && expired;

  apb_timeout_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_timeout_cnt (
    .pclock  (pclock),
    .preset  (preset),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !pready),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_ff @(posedge pclock) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (complete || timed_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address phase registers only load on acceptance so they hold through ACCESS and IDLE.
  always_ff @(posedge pclock) begin
    if (preset) begin
      paddr  <= '0;
      prwd   <= 1'b0;
      pwdata <= '0;
      psel   <= '0;
    end else begin
      if (accept) begin
        paddr <= cmd_addr;
        prwd  <= cmd_write;
        psel  <= decode_psel(cmd_addr[PSEL_LSB +: 4]);
        if (cmd_write) begin
          pwdata <= cmd_wdata;
        end
      end else if (complete || timed_out) begin
        psel <= '0;
      end
    end
  end

  always_ff @(posedge pclock) begin
    if (preset) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= complete || timed_out;
      if (complete) begin
        rsp_rdata   <= prwd ? '0 : prdata;
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (timed_out) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl with an 8-cycle timeout.
// Expected latency, select and response come from a transaction-level model of the transfer rules.
module tb_apb_master_ctrl;

  localparam int LIMIT = 8;

  logic        pclock;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        prwd;
  logic [31:0] pwdata;
  logic [15:0] psel;
  logic        penable;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_wdata = 32'h0;

  apb_master_ctrl #(
    .PADDR_WIDTH    (32),
    .PWDATA_WIDTH   (32),
    .PRDATA_WIDTH   (32),
    .PSEL_LSB       (12),
    .TIMEOUT_CYCLES (LIMIT)
  ) dut (
    .pclock      (pclock),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .paddr       (paddr),
    .prwd        (prwd),
    .pwdata      (pwdata),
    .psel        (psel),
    .penable     (penable),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  initial pclock = 1'b0;
  always #5 pclock = ~pclock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_psel"},      32'(psel),        32'h0);
    check_output({tag, "_penable"},   32'(penable),     32'h0);
    check_output({tag, "_paddr"},     paddr,            32'h0);
    check_output({tag, "_prwd"},      32'(prwd),        32'h0);
    check_output({tag, "_pwdata"},    pwdata,           32'h0);
    check_output({tag, "_rsp_valid"}, 32'(rsp_valid),   32'h0);
    check_output({tag, "_rsp_rdata"}, rsp_rdata,        32'h0);
    check_output({tag, "_rsp_err"},   32'(rsp_err),     32'h0);
    check_output({tag, "_rsp_to"},    32'(rsp_timeout), 32'h0);
    check_output({tag, "_cmd_ready"}, 32'(cmd_ready),   32'h0);
  endtask

  // One command from IDLE to response; the bench plays the slave, stalling `waits` ACCESS cycles.
  task automatic apply_stimulus(input string tag, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int waits,
                                input logic [31:0] rd, input bit slverr);
    bit          exp_to;
    int          exp_acc;
    int          exp_lat;
    logic [15:0] exp_sel;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          hold_ok;
    int          cycle;
    int          acc;
    int          sel_cnt;

    exp_to    = (waits > LIMIT);
    exp_acc   = (exp_to ? LIMIT : waits) + 1;
    exp_lat   = 2 + exp_acc;
    exp_sel   = 16'h1 << addr[15:12];
    exp_rdata = (wr || exp_to) ? 32'h0 : rd;
    exp_err   = exp_to ? 1'b1 : slverr;

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    #1;
    check_output({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    if (wr) model_wdata = wdata;
    @(posedge pclock);
    @(negedge pclock);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_write = ~wr;

    hold_ok = 1'b1;
    cycle   = 1;
    acc     = 0;
    sel_cnt = 0;
    while (cycle <= 60 && !rsp_valid) begin
      if (psel !== exp_sel || paddr !== addr || prwd !== wr || pwdata !== model_wdata) hold_ok = 1'b0;
      if (cycle == 1 && penable !== 1'b0) hold_ok = 1'b0;
      if (psel != 16'h0) sel_cnt++;
      if (penable === 1'b1) begin
        if (acc == waits) begin
          pready  = 1'b1;
          prdata  = rd;
          pslverr = slverr;
        end else begin
          pready  = 1'b0;
          prdata  = $urandom;
          pslverr = 1'b1;
        end
        acc++;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'b1;
      end
      @(negedge pclock);
      cycle++;
    end
    pready  = 1'b0;
    pslverr = 1'b0;

    check_output({tag, "_rsp_seen"},   32'(rsp_valid),   32'h1);
    check_output({tag, "_latency"},    32'(cycle),       32'(exp_lat));
    check_output({tag, "_hold"},       32'(hold_ok),     32'h1);
    check_output({tag, "_access_cyc"}, 32'(acc),         32'(exp_acc));
    check_output({tag, "_psel_cyc"},   32'(sel_cnt),     32'(exp_acc + 1));
    check_output({tag, "_rdata"},      rsp_rdata,        exp_rdata);
    check_output({tag, "_err"},        32'(rsp_err),     32'(exp_err));
    check_output({tag, "_timeout"},    32'(rsp_timeout), 32'(exp_to));
    check_output({tag, "_idle_psel"},  32'(psel),        32'h0);
    check_output({tag, "_idle_pen"},   32'(penable),     32'h0);
    check_output({tag, "_idle_paddr"}, paddr,            addr);
    check_output({tag, "_rsp_ready"},  32'(cmd_ready),   32'h1);
    @(negedge pclock);
    check_output({tag, "_rsp_pulse"},  32'(rsp_valid),   32'h0);
  endtask

  initial begin
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    pready    = 1'b0;
    prdata    = 32'h0;
    pslverr   = 1'b0;

    repeat (3) @(negedge pclock);
    check_all_zero("reset");
    preset = 1'b0;
    #1;
    check_output("post_reset_ready", 32'(cmd_ready), 32'h1);

    apply_stimulus("wr_fast",    1'b1, 32'h0000_3010, 32'hDEAD_BEEF, 0,  32'h0,         1'b0);
    apply_stimulus("rd_wait4",   1'b0, 32'h0000_F004, 32'h0,         4,  32'h1234_5678, 1'b0);
    apply_stimulus("rd_slverr",  1'b0, 32'h0000_1000, 32'h0,         3,  32'hCAFE_0001, 1'b1);
    apply_stimulus("rd_ignore",  1'b0, 32'h0000_2000, 32'h0,         2,  32'h0BAD_F00D, 1'b0);
    apply_stimulus("rd_timeout", 1'b0, 32'h0000_7000, 32'h0,         30, 32'h5555_AAAA, 1'b0);
    apply_stimulus("wr_limit",   1'b1, 32'h0000_A0F0, 32'h0102_0304, LIMIT, 32'h0,      1'b1);
    apply_stimulus("rd_limit",   1'b0, 32'h0000_B0F0, 32'h0,         LIMIT, 32'h7777_8888, 1'b0);

    for (int i = 0; i < 14; i++) begin
      apply_stimulus($sformatf("rnd%0d", i), 1'($urandom), $urandom, $urandom,
                     int'($urandom_range(0, LIMIT + 3)), $urandom, 1'($urandom));
    end

    // Reset in the second ACCESS cycle with a ready slave and a command held pending.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_5008;
    @(posedge pclock);
    @(negedge pclock);
    @(negedge pclock);
    @(negedge pclock);
    check_output("rst_in_access", 32'(penable), 32'h1);
    preset  = 1'b1;
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'hFFFF_FFFF;
    @(negedge pclock);
    check_all_zero("rst_abort");
    @(negedge pclock);
    check_output("rst_hold_psel",  32'(psel),      32'h0);
    check_output("rst_hold_rsp",   32'(rsp_valid), 32'h0);
    preset  = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    model_wdata = 32'h0;
    #1;
    check_output("rst_release_ready", 32'(cmd_ready), 32'h1);
    @(negedge pclock);
    check_output("rst_accept_psel", 32'(psel),    32'h0020);
    check_output("rst_accept_pen",  32'(penable), 32'h0);
    cmd_valid = 1'b0;
    @(negedge pclock);
    pready = 1'b1;
    prdata = 32'h600D_D00D;
    @(negedge pclock);
    pready = 1'b0;
    check_output("rst_next_rsp",   32'(rsp_valid), 32'h1);
    check_output("rst_next_rdata", rsp_rdata,      32'h600D_D00D);
    @(negedge pclock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: ports pclock and preset.
REQ-002 Parameters SHALL be:
- PADDR_WIDTH, 32, address width
- PWDATA_WIDTH, 32, write data width
- PRDATA_WIDTH, 32, read data width
- PSEL_LSB, 12, LSB of the 4-bit slave-index field in cmd_addr
- TIMEOUT_CYCLES, 255, maximum ACCESS wait cycles; 0 disables the timeout
REQ-003 Ports SHALL be:
- pclock  in  1  clock
- preset  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  PADDR_WIDTH  byte address
- cmd_wdata  in  PWDATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  PRDATA_WIDTH  read data
- rsp_err  out  1  pslverr or timeout
- rsp_timeout  out  1  timeout occurred
- paddr  out  PADDR_WIDTH  APB address
- prwd  out  1  APB direction
- pwdata  out  PWDATA_WIDTH  APB write data
- psel  out  16  one-hot APB select
- penable  out  1  APB enable
- pready  in  1  APB ready
- prdata  in  PRDATA_WIDTH  APB read data
- pslverr  in  1  APB slave error

Function
REQ-004 FSM SHALL have three states: IDLE, SETUP, ACCESS.
REQ-005 cmd_ready SHALL equal 1 only in IDLE and not in reset; a command is accepted when cmd_valid && cmd_ready.
REQ-006 On acceptance at edge N, the block SHALL enter SETUP at N+1 and register paddr=cmd_addr, prwd=cmd_write, pwdata=cmd_wdata (writes only), and psel = 1 << cmd_addr[PSEL_LSB+3:PSEL_LSB].
REQ-007 SETUP SHALL last exactly one cycle with penable=0 and psel asserted, then unconditionally enter ACCESS.
REQ-008 ACCESS SHALL drive penable=1, and SHALL hold psel, paddr, prwd and pwdata stable until the transfer completes.
REQ-009 Completion SHALL be the first ACCESS cycle with pready=1; the next state SHALL be IDLE with psel=0 and penable=0.
REQ-010 rsp_valid SHALL pulse for exactly one cycle, in the cycle after completion.
- rsp_rdata = prdata captured at completion for reads, 0 for writes.
- rsp_err = pslverr captured at completion.
- rsp_timeout = 0.
REQ-011 pslverr and prdata SHALL be ignored in every cycle except a pready=1 ACCESS cycle.
REQ-012 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-013 When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with pready still 0, the block SHALL abort to IDLE and pulse rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-014 If pready=1 arrives in the same cycle the counter reaches its limit, the block SHALL report normal completion, not a timeout.
REQ-015 The minimum command-to-response latency SHALL be 3 cycles (pready=1 in the first ACCESS cycle); the next command SHALL be accepted no earlier than the rsp_valid cycle.
REQ-016 In IDLE, paddr, prwd and pwdata SHALL hold their last values; psel and penable SHALL be 0.

Reset
REQ-017 When preset=1 at an edge, the block SHALL enter IDLE, and the following SHALL be 0: psel, penable, paddr, prwd, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, and the wait counter.
REQ-018 A reset during SETUP or ACCESS SHALL abort the transfer without producing rsp_valid; cmd_ready SHALL be 0 while preset=1.

Structure
REQ-019 Package apb_master_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS), the PSEL width constant 16, and the default parameter values.
REQ-020 The wait counter SHALL be a sub-module, apb_timeout_cnt, with inputs clear, enable and limit, and output expired.

Verification
REQ-021 Write addr=0x0000_3010, data=0xDEAD_BEEF, pready=1 immediately -> psel=0x0008 for 2 cycles, penable high for 1 cycle, rsp_valid at cycle 3, rsp_err=0.
REQ-022 Read addr=0x0000_F004, pready low for 4 ACCESS cycles, prdata=0x1234_5678 -> psel=0x8000 and paddr stable throughout, rsp_rdata=0x1234_5678.
REQ-023 Read with pready=1 and pslverr=1 -> rsp_err=1, rsp_timeout=0; pslverr=1 in earlier wait cycles has no effect.
REQ-024 TIMEOUT_CYCLES=8 with pready held 0 -> abort after 8 wait cycles, rsp_err=1, rsp_timeout=1, psel=0 the next cycle; a repeat with pready=1 on the limit cycle -> normal completion.
REQ-025 preset asserted in the 2nd ACCESS cycle -> next cycle all outputs 0 and no rsp_valid; cmd_valid held high through reset -> command accepted only in the first cycle after preset falls.
